// File: rtl/page_walker_if.sv
// Miss/memory/fill channel bundle of the page walker. The walker uses the slave view.
// The TLB-plus-memory side uses the master view.
interface page_walker_if #(
  parameter int PCID_W = 12
) ();
  logic              miss_valid;
  logic              miss_ready;
  logic [63:0]       miss_va;
  logic [PCID_W-1:0] miss_pcid;
  logic [63:0]       cr3;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [63:0]       mem_req_addr;
  logic              mem_resp_valid;
  logic [63:0]       mem_resp_data;
  logic              fill_valid;
  logic              fill_ready;
  logic [63:0]       fill_va;
  logic [63:0]       fill_pa;
  logic [PCID_W-1:0] fill_pcid;
  logic              fill_fault;

  modport master (
    output miss_valid, miss_va, miss_pcid, cr3, mem_req_ready,
           mem_resp_valid, mem_resp_data, fill_ready,
    input  miss_ready, mem_req_valid, mem_req_addr,
           fill_valid, fill_va, fill_pa, fill_pcid, fill_fault
  );

  modport slave (
    input  miss_valid, miss_va, miss_pcid, cr3, mem_req_ready,
           mem_resp_valid, mem_resp_data, fill_ready,
    output miss_ready, mem_req_valid, mem_req_addr,
           fill_valid, fill_va, fill_pa, fill_pcid, fill_fault
  );
endinterface

// File: rtl/page_walker.sv
// 4-level x86-64 page walker: 2 cycles per level, request and fill registered and held until ready.
// Macro PAGE_WALKER_LARGE_PAGE_EN enables 2M/1G leaves; otherwise PS is ignored below level 3.
module page_walker #(
  parameter int PA_W   = 52,
  parameter int PCID_W = 12
) (
  input  logic         clk,
  input  logic         rst,
  page_walker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

  localparam logic [63:0] PA_MASK = (PA_W >= 64) ? '1 : ((64'd1 << PA_W) - 64'd1);

  state_t            state_q, state_d;
  logic [1:0]        lvl_q, lvl_d;
  logic [63:0]       addr_q, addr_d;
  logic [63:0]       va_q, va_d;
  logic [63:0]       pa_q, pa_d;
  logic [PCID_W-1:0] pcid_q, pcid_d;
  logic              fault_q, fault_d;
  logic [63:0]       pte;
  logic              canonical;
  logic              unused_bits;

  function automatic logic [63:0] pte_addr(input logic [39:0] pfn, input logic [63:0] va,
                                           input logic [1:0] lvl);
    logic [8:0] idx;
    idx = 9'(va >> (12 + 9 * int'(lvl)));
    return {12'b0, pfn, idx, 3'b000};
  endfunction

  assign pte         = bus.mem_resp_data;
  assign canonical   = (&bus.miss_va[63:47]) | ~(|bus.miss_va[63:47]);
  assign unused_bits = ^{bus.cr3[63:52], bus.cr3[11:0], pte[63:52], pte[11:8], pte[6:1]};

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    addr_d  = addr_q;
    va_d    = va_q;
    pa_d    = pa_q;
    pcid_d  = pcid_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (bus.miss_valid) begin
          va_d    = bus.miss_va;
          pcid_d  = bus.miss_pcid;
          lvl_d   = 2'd3;
          pa_d    = '0;
          fault_d = 1'b0;
          if (canonical) begin
            addr_d  = pte_addr(bus.cr3[51:12], bus.miss_va, 2'd3);
            state_d = REQ;
          end else begin
            fault_d = 1'b1;
            state_d = FILL;
          end
        end
      end
      REQ: begin
        if (bus.mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_resp_valid) begin
          if (!pte[0]) begin
            fault_d = 1'b1;
            state_d = FILL;
          end else if (lvl_q == 2'd0) begin
            pa_d    = {12'b0, pte[51:12], va_q[11:0]} & PA_MASK;
            state_d = FILL;
          end else if (pte[7] && (lvl_q == 2'd3)) begin
            fault_d = 1'b1;
            state_d = FILL;
`ifdef PAGE_WALKER_LARGE_PAGE_EN
          end else if (pte[7] && (lvl_q == 2'd2)) begin
            pa_d    = {12'b0, pte[51:30], va_q[29:0]} & PA_MASK;
            state_d = FILL;
          end else if (pte[7] && (lvl_q == 2'd1)) begin
            pa_d    = {12'b0, pte[51:21], va_q[20:0]} & PA_MASK;
            state_d = FILL;
`endif
          end else begin
            // Table pointer: this PTE becomes the base of the next level down.
            addr_d  = pte_addr(pte[51:12], va_q, lvl_q - 2'd1);
            lvl_d   = lvl_q - 2'd1;
            state_d = REQ;
          end
        end
      end
      FILL: begin
        if (bus.fill_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lvl_q   <= '0;
      addr_q  <= '0;
      va_q    <= '0;
      pa_q    <= '0;
      pcid_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      addr_q  <= addr_d;
      va_q    <= va_d;
      pa_q    <= pa_d;
      pcid_q  <= pcid_d;
      fault_q <= fault_d;
    end
  end

  // Gate with rst so nothing is offered while reset is held.
  assign bus.miss_ready    = (state_q == IDLE) && !rst;
  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_req_addr  = addr_q;
  assign bus.fill_valid    = (state_q == FILL);
  assign bus.fill_va       = va_q;
  assign bus.fill_pa       = pa_q;
  assign bus.fill_pcid     = pcid_q;
  assign bus.fill_fault    = fault_q;
endmodule

// File: tb/tb_page_walker.sv
// Directed bench for page_walker: zero-wait memory model driven from the stimulus sequence.
// Covers 4K/2M/1G walks, faults, backpressure and reset mid-walk.
module tb_page_walker;
  logic clk;
  logic rst;

  page_walker_if #(.PCID_W(12)) bus ();

  page_walker #(.PA_W(52), .PCID_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] VA = 64'h0000_0080_4020_1ABC;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] pte_tbl [4];
  logic [63:0] addr_tbl[4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tbl(input logic [63:0] a0, a1, a2, a3, p0, p1, p2, p3);
    addr_tbl[0] = a0; addr_tbl[1] = a1; addr_tbl[2] = a2; addr_tbl[3] = a3;
    pte_tbl[0]  = p0; pte_tbl[1]  = p1; pte_tbl[2]  = p2; pte_tbl[3]  = p3;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " miss_ready"},    64'(bus.miss_ready),    64'd0);
    check({tag, " mem_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
    check({tag, " fill_valid"},    64'(bus.fill_valid),    64'd0);
    check({tag, " fill_fault"},    64'(bus.fill_fault),    64'd0);
    check({tag, " mem_req_addr"},  bus.mem_req_addr,       64'd0);
    check({tag, " fill_va"},       bus.fill_va,            64'd0);
    check({tag, " fill_pa"},       bus.fill_pa,            64'd0);
    check({tag, " fill_pcid"},     64'(bus.fill_pcid),     64'd0);
  endtask

  task automatic run_walk(input string tag, input logic [63:0] va, input logic [11:0] pcid,
                          input int exp_req, input int exp_cyc, input logic [63:0] exp_pa,
                          input logic exp_fault, input int req_stall, input int fill_stall,
                          input logic hold_miss);
    int   cyc;
    int   nreq;
    int   stall;
    logic pend;
    bus.miss_valid    = 1'b1;
    bus.miss_va       = va;
    bus.miss_pcid     = pcid;
    bus.mem_req_ready = 1'b0;
    bus.fill_ready    = 1'b0;
    #1;
    check({tag, " idle miss_ready"}, 64'(bus.miss_ready), 64'd1);
    tick();
    bus.miss_valid = hold_miss;
    bus.miss_va    = ~va;
    bus.miss_pcid  = ~pcid;
    cyc   = 1;
    nreq  = 0;
    pend  = 1'b0;
    stall = req_stall;
    while (bus.fill_valid !== 1'b1 && cyc < 40) begin
      bus.mem_resp_valid = pend;
      bus.mem_resp_data  = (pend && nreq >= 1 && nreq <= 4) ? pte_tbl[nreq-1] : 64'd0;
      pend = 1'b0;
      bus.mem_req_ready = 1'b0;
      if (hold_miss) check({tag, " busy miss_ready"}, 64'(bus.miss_ready), 64'd0);
      if (bus.mem_req_valid === 1'b1) begin
        if (nreq < 4) check($sformatf("%s req%0d addr", tag, nreq), bus.mem_req_addr, addr_tbl[nreq]);
        if (stall > 0) begin
          stall--;
        end else begin
          bus.mem_req_ready = 1'b1;
          pend = 1'b1;
          nreq++;
        end
      end
      tick();
      cyc++;
    end
    bus.mem_resp_valid = 1'b0;
    bus.mem_req_ready  = 1'b0;
    check({tag, " fill cycle"}, 64'(cyc),            64'(exp_cyc));
    check({tag, " req count"},  64'(nreq),           64'(exp_req));
    check({tag, " fill_valid"}, 64'(bus.fill_valid), 64'd1);
    check({tag, " fill_fault"}, 64'(bus.fill_fault), 64'(exp_fault));
    check({tag, " fill_pa"},    bus.fill_pa,         exp_pa);
    check({tag, " fill_va"},    bus.fill_va,         va);
    check({tag, " fill_pcid"},  64'(bus.fill_pcid),  64'(pcid));
    for (int i = 0; i < fill_stall; i++) begin
      tick();
      check({tag, " held fill_valid"}, 64'(bus.fill_valid), 64'd1);
      check({tag, " held fill_pa"},    bus.fill_pa,         exp_pa);
      check({tag, " held fill_va"},    bus.fill_va,         va);
      check({tag, " held fill_pcid"},  64'(bus.fill_pcid),  64'(pcid));
      check({tag, " held miss_ready"}, 64'(bus.miss_ready), 64'd0);
    end
    bus.miss_valid = 1'b0;
    bus.fill_ready = 1'b1;
    tick();
    bus.fill_ready = 1'b0;
    check({tag, " post fill_valid"}, 64'(bus.fill_valid), 64'd0);
    check({tag, " post miss_ready"}, 64'(bus.miss_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus.miss_valid     = 1'b0;
    bus.miss_va        = '0;
    bus.miss_pcid      = '0;
    bus.cr3            = 64'h1000;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    bus.fill_ready     = 1'b0;
    repeat (2) tick();
    check_zero("reset");
    rst = 1'b0;

    set_tbl(64'h1008, 64'h2008, 64'h3008, 64'h4008,
            64'h2003, 64'h3003, 64'h4003, 64'h5_6789_A003);
    run_walk("4K", VA, 12'hABC, 4, 9, 64'h5_6789_AABC, 1'b0, 0, 0, 1'b0);

`ifdef PAGE_WALKER_LARGE_PAGE_EN
    set_tbl(64'h1008, 64'h2008, 64'h3008, 64'h0,
            64'h2003, 64'h3003, 64'h60_0083, 64'h0);
    run_walk("2M", VA, 12'h123, 3, 7, 64'h60_1ABC, 1'b0, 0, 0, 1'b0);
    set_tbl(64'h1008, 64'h2008, 64'h0, 64'h0,
            64'h2003, 64'h4000_0083, 64'h0, 64'h0);
    run_walk("1G", VA, 12'h456, 2, 5, 64'h4020_1ABC, 1'b0, 0, 0, 1'b0);
`else
    set_tbl(64'h1008, 64'h2008, 64'h3008, 64'h60_0008,
            64'h2003, 64'h3003, 64'h60_0083, 64'h5_6789_A003);
    run_walk("2M", VA, 12'h123, 4, 9, 64'h5_6789_AABC, 1'b0, 0, 0, 1'b0);
    set_tbl(64'h1008, 64'h2008, 64'h4000_0008, 64'h4008,
            64'h2003, 64'h4000_0083, 64'h4003, 64'h5_6789_A003);
    run_walk("1G", VA, 12'h456, 4, 9, 64'h5_6789_AABC, 1'b0, 0, 0, 1'b0);
`endif

    set_tbl(64'h1008, 64'h2008, 64'h0, 64'h0,
            64'h2003, 64'h3002, 64'h0, 64'h0);
    run_walk("notpresent", VA, 12'h789, 2, 5, 64'h0, 1'b1, 0, 0, 1'b0);

    set_tbl(64'h1008, 64'h0, 64'h0, 64'h0,
            64'h2083, 64'h0, 64'h0, 64'h0);
    run_walk("l3ps", VA, 12'h00F, 1, 3, 64'h0, 1'b1, 0, 0, 1'b0);

    run_walk("noncanon", 64'h0001_0000_0000_0000, 12'h321, 0, 1, 64'h0, 1'b1, 0, 0, 1'b0);

    set_tbl(64'h1008, 64'h2008, 64'h3008, 64'h4008,
            64'h2003, 64'h3003, 64'h4003, 64'h5_6789_A003);
    run_walk("backpressure", VA, 12'hFED, 4, 14, 64'h5_6789_AABC, 1'b0, 5, 4, 1'b1);

    // Abort a walk while waiting on the level-2 PTE.
    bus.miss_valid    = 1'b1;
    bus.miss_va       = VA;
    bus.miss_pcid     = 12'h555;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.miss_valid = 1'b0;
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 64'h2003;
    tick();
    bus.mem_resp_valid = 1'b0;
    check("abort l2 addr", bus.mem_req_addr, 64'h2008);
    tick();
    check("abort in wait", 64'(bus.mem_req_valid), 64'd0);
    rst = 1'b1;
    tick();
    check_zero("abort reset");
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 64'h3003;
    run_walk("after reset", VA, 12'h2A2, 4, 9, 64'h5_6789_AABC, 1'b0, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
